// File: rtl/mips_hazard_scoreboard_pkg.sv
// Shared types for the MIPS hazard scoreboard: scoreboard entry, register address and forward select.
package mips_hazard_scoreboard_pkg;

  // Storage widths are fixed maxima; the top zero-extends narrower configurations into them.
  localparam int REG_AW_MAX = 8;
  localparam int SEL_W_MAX  = 4;

  typedef logic [REG_AW_MAX-1:0] RegAddr;
  typedef logic [SEL_W_MAX-1:0]  FwdSel;

  typedef struct packed {
    logic   valid;
    logic   wr;
    logic   load;
    RegAddr dst;
  } SbEntry;

  localparam SbEntry SB_EMPTY = '{valid: 1'b0, wr: 1'b0, load: 1'b0, dst: '0};

  // Register 0 is hardwired, so it never produces a forwardable value.
  function automatic logic producer_match(input SbEntry e, input RegAddr src, input logic used);
    return used && e.valid && e.wr && (e.dst == src) && (e.dst != '0);
  endfunction

endpackage

// File: rtl/mips_hazard_scoreboard_hazard_match.sv
// Youngest-producer search for one source operand across the tracked post-decode stages.
module mips_hazard_scoreboard_hazard_match
  import mips_hazard_scoreboard_pkg::*;
#(
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1
) (
  input  SbEntry [DEPTH:1] entries,
  input  RegAddr           src,
  input  logic             used,
  output logic             hit,
  output logic             ready,
  output FwdSel            stage
);

  // Scan oldest to youngest so the youngest match overwrites any older one.
  always_comb begin
    hit   = 1'b0;
    ready = 1'b0;
    stage = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (producer_match(entries[k], src, used)) begin
        hit   = 1'b1;
        ready = !entries[k].load || (k > LOAD_LAT);
        stage = FwdSel'(k);
      end
    end
  end

endmodule

// File: rtl/mips_hazard_scoreboard.sv
// Parametrised hazard/forwarding controller: scoreboard of in-flight writes, stall/bubble/flush/freeze and forward selects.
// Optional HAZARD_PERF_EN adds saturating stall and flush event counters.
module mips_hazard_scoreboard
  import mips_hazard_scoreboard_pkg::*;
#(
  parameter  int NREG     = 32,
  parameter  int DEPTH    = 3,
  parameter  int LOAD_LAT = 1,
  localparam int AW       = $clog2(NREG),
  localparam int SW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          d_valid,
  input  logic [AW-1:0] d_rs,
  input  logic [AW-1:0] d_rt,
  input  logic          d_rs_used,
  input  logic          d_rt_used,
  input  logic          d_wr,
  input  logic [AW-1:0] d_dst,
  input  logic          d_load,
  input  logic          x_taken,
  input  logic          mem_busy,
  output logic          stall_if,
  output logic          stall_d,
  output logic          bubble_x,
  output logic          flush_fd,
  output logic          freeze,
  output logic [SW-1:0] fwd_rs_sel,
  output logic [SW-1:0] fwd_rt_sel
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]   perf_stall_cnt,
  output logic [31:0]   perf_flush_cnt
`endif
);

  if (AW > REG_AW_MAX || SW > SEL_W_MAX) begin : g_width_check
    $error("mips_hazard_scoreboard: NREG or DEPTH exceeds package storage widths");
  end

  SbEntry [DEPTH:1] sb;
  SbEntry           issue_entry;

  logic  rs_hit, rs_ready, rt_hit, rt_ready;
  FwdSel rs_stage, rt_stage;
  logic  taken, rs_fwd, rt_fwd, load_use, issue;

  mips_hazard_scoreboard_hazard_match #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT)) u_match_rs (
    .entries (sb),
    .src     (RegAddr'(d_rs)),
    .used    (d_valid && d_rs_used),
    .hit     (rs_hit),
    .ready   (rs_ready),
    .stage   (rs_stage)
  );

  mips_hazard_scoreboard_hazard_match #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT)) u_match_rt (
    .entries (sb),
    .src     (RegAddr'(d_rt)),
    .used    (d_valid && d_rt_used),
    .hit     (rt_hit),
    .ready   (rt_ready),
    .stage   (rt_stage)
  );

  // Outputs are qualified by rst so an asserted reset forces every output low immediately.
  always_comb begin
    taken      = x_taken && !mem_busy;
    rs_fwd     = rs_hit && rs_ready;
    rt_fwd     = rt_hit && rt_ready;
    load_use   = (rs_hit && !rs_ready) || (rt_hit && !rt_ready);
    freeze     = rst && mem_busy;
    stall_d    = rst && (mem_busy || (load_use && !taken));
    stall_if   = stall_d;
    bubble_x   = rst && !mem_busy && (taken || load_use);
    flush_fd   = rst && taken;
    fwd_rs_sel = (rst && rs_fwd) ? SW'(rs_stage) : '0;
    fwd_rt_sel = (rst && rt_fwd) ? SW'(rt_stage) : '0;
  end

  always_comb begin
    issue       = d_valid && !stall_d && !bubble_x;
    issue_entry = SB_EMPTY;
    if (issue) begin
      issue_entry.valid = 1'b1;
      issue_entry.wr    = d_wr;
      issue_entry.load  = d_load;
      issue_entry.dst   = RegAddr'(d_dst);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb <= '0;
    end else if (!mem_busy) begin
      sb[1] <= issue_entry;
      for (int k = 2; k <= DEPTH; k++) begin
        sb[k] <= sb[k-1];
      end
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_d && !freeze && (perf_stall_cnt != '1)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (flush_fd && (perf_flush_cnt != '1))           perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule
